// File: rtl/mdu_ex_pkg.sv
// mdu_ex_pkg: shared definitions for the EX-stage multiply/divide unit.
// Holds the md_op encodings (shared with the ID-stage decoder), the FSM state
// encodings and the default operation latencies.
package mdu_ex_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational multiply/divide datapath.
// Ports:
//   a, b   : RS / RT operands
//   md_op  : operation code (md_op_e encoding)
//   res    : {hi, lo} result; product for MULT/MULTU, {remainder, quotient}
//            for DIV/DIVU, zero for all other codes and for division by zero
module mdu_calc
    import mdu_ex_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  md_op,
    output logic [63:0] res
);

    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb_safe;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] ub_safe;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               div_zero;
    logic               div_ovf;

    // Sign/zero extension to 64 bits so both products are full width.
    assign sa64   = {{32{a[31]}}, a};
    assign sb64   = {{32{b[31]}}, b};
    assign prod_s = sa64 * sb64;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Divisor is replaced by 1 for the zero and INT_MIN/-1 cases so the
    // divider never sees an undefined operation; those results are muxed.
    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign sa       = $signed(a);
    assign sb_safe  = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
    assign quot_s   = sa / sb_safe;
    assign rem_s    = sa % sb_safe;
    assign ub_safe  = div_zero ? 32'd1 : b;
    assign quot_u   = a / ub_safe;
    assign rem_u    = a % ub_safe;

    // Result select by opcode.
    always_comb begin
        res = 64'd0;
        case (md_op_e'(md_op))
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV: begin
                if (div_ovf) begin
                    res = {32'd0, 32'h8000_0000};
                end else if (!div_zero) begin
                    res = {rem_s, quot_s};
                end
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    res = {rem_u, quot_u};
                end
            end
            default: res = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ex.sv
// mdu_ex: multi-cycle multiply/divide unit with architectural HI/LO.
// Optional feature macro: MDU_CANCEL_EN adds the cancel input (exception flush).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : EX-stage instruction is MD-class, md_op valid
//   md_op      : operation code (md_op_e encoding)
//   a, b       : forwarded RS / RT operands, sampled at the accepting edge
//   cancel     : (MDU_CANCEL_EN only) abort in-flight operation, beats start
//   busy       : a multiply/divide is in flight
//   hi, lo     : architectural HI / LO registers
module mdu_ex
    import mdu_ex_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               dz;
    logic [63:0]        calc_res;
    logic               flush_c;
    md_op_e             op_c;

    assign op_c = md_op_e'(md_op);

`ifdef MDU_CANCEL_EN
    assign flush_c = cancel;
`else
    assign flush_c = 1'b0;
`endif

    mdu_calc u_calc (
        .a     (a),
        .b     (b),
        .md_op (md_op),
        .res   (calc_res)
    );

    // FSM, latency counter, pending result and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            dz      <= 1'b0;
        end else if (flush_c) begin
            // Flush: drop pending result, HI/LO untouched, start ignored.
            state   <= ST_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            dz      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op_c)
                            OP_MULT, OP_MULTU: begin
                                pend_hi <= calc_res[63:32];
                                pend_lo <= calc_res[31:0];
                                dz      <= 1'b0;
                                cnt     <= CNT_W'(MULT_CYCLES);
                                busy    <= 1'b1;
                                state   <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi <= calc_res[63:32];
                                pend_lo <= calc_res[31:0];
                                dz      <= (b == 32'd0);
                                cnt     <= CNT_W'(DIV_CYCLES);
                                busy    <= 1'b1;
                                state   <= ST_DIV;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    // Last busy cycle: commit (unless divide-by-zero) and retire.
                    if (cnt == CNT_W'(1)) begin
                        if (!dz) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ex.sv
// tb_mdu_ex: scoreboard bench for mdu_ex. Stimulus pushes the expected
// HI/LO and busy length per accepted op; a monitor pops and compares.
module tb_mdu_ex;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic        is_md;
        int          n;
        int          id;
        logic [31:0] ehi;
        logic [31:0] elo;
    } item_t;

    item_t       q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_items = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ex #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .a      (a),
        .b      (b),
`ifdef MDU_CANCEL_EN
        .cancel (cancel),
`endif
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic on 64-bit integers; caller avoids division by zero.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (op)
            3'd0:    return 64'(sx * sy);
            3'd1:    return ux * uy;
            3'd2:    return {32'(sx % sy), 32'(sx / sy)};
            default: return {32'(ux % uy), 32'(ux / uy)};
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 300) begin
            g++;
            @(negedge clk);
        end
        if (g >= 300) chk("idle_wait_timeout", 64'(busy), 64'd0);
    endtask

    // Issue one op in an idle cycle, update the model and queue the expectation.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        item_t       it;
        logic [63:0] r;
        wait_idle();
        start = 1'b1;
        md_op = op;
        a     = x;
        b     = y;
        if (op <= 3'd3) begin
            if (op <= 3'd1 || y != 32'd0) begin
                r    = ref_md(op, x, y);
                m_hi = r[63:32];
                m_lo = r[31:0];
            end
        end else if (op == 3'd4) begin
            m_hi = x;
        end else if (op == 3'd5) begin
            m_lo = x;
        end
        it.is_md = (op <= 3'd3);
        it.n     = (op <= 3'd1) ? MULT_N : DIV_N;
        it.id    = n_items;
        it.ehi   = m_hi;
        it.elo   = m_lo;
        n_items++;
        if (op <= 3'd5) q.push_back(it);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Monitor: pops at the accepting edge, measures busy, checks HI/LO.
    initial begin
        item_t it;
        int    len;
        forever begin
            @(posedge clk);
            if (q.size() != 0) begin
                it = q.pop_front();
                @(negedge clk);
                if (it.is_md) begin
                    len = 0;
                    while (busy && len < 300) begin
                        len++;
                        @(negedge clk);
                    end
                    chk($sformatf("busy_len[%0d]", it.id), 64'(len), 64'(it.n));
                end
                chk($sformatf("hi[%0d]", it.id), {32'd0, hi}, {32'd0, it.ehi});
                chk($sformatf("lo[%0d]", it.id), {32'd0, lo}, {32'd0, it.elo});
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        // Asynchronous reset mid-operation, checked before any clock edge.
        @(negedge clk);
        start = 1'b1; md_op = 3'd4; a = 32'h0000_DEAD;
        @(negedge clk);
        md_op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_pre_reset", {32'd0, hi}, 64'h0000_DEAD);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_busy", 64'(busy), 64'd0);
        chk("async_reset_hi", {32'd0, hi}, 64'd0);
        chk("async_reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases.
        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        issue(3'd3, 32'd7, 32'd0);
        issue(3'd0, 32'd3, 32'd4);
        // Ops presented while busy must be ignored.
        start = 1'b1; md_op = 3'd4; a = 32'h1234;
        @(negedge clk);
        md_op = 3'd2; a = 32'd50; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        issue(3'd5, 32'h55, 32'd0);
        issue(3'd6, 32'hAAAA_AAAA, 32'd1);
        issue(3'd7, 32'hBBBB_BBBB, 32'd1);
        issue(3'd1, 32'd6, 32'd7);

`ifdef MDU_CANCEL_EN
        begin
            item_t it;
            wait_idle();
            start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
            it.is_md = 1'b1; it.n = 4; it.id = n_items; it.ehi = m_hi; it.elo = m_lo;
            n_items++;
            q.push_back(it);
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            cancel = 1'b1;
            start = 1'b1; md_op = 3'd4; a = 32'h9999;
            @(negedge clk);
            cancel = 1'b0;
            start = 1'b0;
            issue(3'd0, 32'd2, 32'd3);
        end
`endif

        // Randomized ops, with occasional ignored starts while busy.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] x;
            logic [31:0] y;
            op = 3'($urandom_range(0, 7));
            x  = pick();
            y  = pick();
            issue(op, x, y);
            if (op <= 3'd3 && $urandom_range(0, 1) == 1) begin
                start = 1'b1;
                md_op = 3'($urandom);
                a     = $urandom;
                b     = $urandom;
                @(negedge clk);
                start = 1'b0;
            end
        end

        wait_idle();
        repeat (20) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
